// File: rtl/chip8_scheduler.sv
// chip8_scheduler: CHIP-8 instruction strobe, 60 Hz frame strobe, delay/sound timers and debug run control.
// Optional CHIP8_SCHED_DISP_WAIT_EN: after a strobe issued during a draw, hold strobes until the next frame.
module chip8_scheduler #(
   parameter int TICK_CYCLES  = 166_666,
   parameter int FRAME_CYCLES = 1_666_667,
   parameter bit START_RUN    = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       proc_busy_in,
   input  logic       disp_wait_in,
   input  logic       pause_in,
   input  logic       resume_in,
   input  logic       step_in,
   input  logic       dt_we_in,
   input  logic       st_we_in,
   input  logic [7:0] timer_data_in,
   output logic       chip8_clk_out,
   output logic       frame_out,
   output logic [7:0] dt_out,
   output logic       sound_on_out,
   output logic       running_out,
   output logic       overrun_out
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_PAUSE, S_STEP} state_t;
   localparam state_t RESET_STATE = START_RUN ? S_RUN : S_PAUSE;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          pending_q, pending_d;
   logic          chip8_clk_q, chip8_clk_d;
   logic          frame_q, frame_d;
   logic [7:0]    dt_q, dt_d;
   logic [7:0]    st_q, st_d;
   logic          sound_q, sound_d;
   logic          running_q, running_d;
   logic          overrun_q, overrun_d;
   logic          due, frame_wrap, want, issue, hold, dec;

`ifdef CHIP8_SCHED_DISP_WAIT_EN
   logic latch_q, latch_d;
   assign hold = latch_q;
`else
   logic unused_disp_wait;
   assign unused_disp_wait = disp_wait_in;
   assign hold = 1'b0;
`endif

   always_comb begin
      // NOTE: every *_d takes its hold value first, so no branch can leave a latch behind.
      state_d     = state_q;
      overrun_d   = overrun_q;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
      latch_d     = latch_q;
`endif
      frame_wrap  = (fcnt_q == FRAME_LAST);
      due         = (state_q == S_RUN) && (tick_q == TICK_LAST);
      fcnt_d      = frame_wrap ? '0 : fcnt_q + 1'b1;
      tick_d      = (state_q != S_RUN || due) ? '0 : tick_q + 1'b1;

      // Single-entry pending slot; a due that finds it occupied is lost.
      want        = pending_q | due;
      issue       = want & ~proc_busy_in & ~hold;
      pending_d   = want & ~issue;
      chip8_clk_d = issue;
      if (due && pending_q) overrun_d = 1'b1;
      if (issue && state_q == S_STEP) state_d = S_PAUSE;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
      if (frame_wrap) latch_d = 1'b0;
      if (issue && disp_wait_in) latch_d = 1'b1;
`endif

      // Debug control overrides the strobe path; pause has priority over resume.
      if (pause_in) begin
         state_d     = S_PAUSE;
         pending_d   = 1'b0;
         chip8_clk_d = 1'b0;
         tick_d      = '0;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
         latch_d     = 1'b0;
`endif
      end else if (resume_in && state_q != S_RUN) begin
         state_d   = S_RUN;
         tick_d    = '0;
         overrun_d = 1'b0;
      end else if (step_in && state_q == S_PAUSE) begin
         state_d   = S_STEP;
         pending_d = 1'b1;
      end

      dec = frame_wrap && (state_q == S_RUN);
      if (dt_we_in)               dt_d = timer_data_in;
      else if (dec && dt_q != 0)  dt_d = dt_q - 8'd1;
      else                        dt_d = dt_q;
      if (st_we_in)               st_d = timer_data_in;
      else if (dec && st_q != 0)  st_d = st_q - 8'd1;
      else                        st_d = st_q;

      frame_d   = frame_wrap;
      sound_d   = (st_d != 8'd0);
      running_d = (state_d == S_RUN);
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= RESET_STATE;
         tick_q      <= '0;
         fcnt_q      <= '0;
         pending_q   <= 1'b0;
         chip8_clk_q <= 1'b0;
         frame_q     <= 1'b0;
         dt_q        <= 8'd0;
         st_q        <= 8'd0;
         sound_q     <= 1'b0;
         running_q   <= START_RUN;
         overrun_q   <= 1'b0;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
         latch_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         fcnt_q      <= fcnt_d;
         pending_q   <= pending_d;
         chip8_clk_q <= chip8_clk_d;
         frame_q     <= frame_d;
         dt_q        <= dt_d;
         st_q        <= st_d;
         sound_q     <= sound_d;
         running_q   <= running_d;
         overrun_q   <= overrun_d;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
         latch_q     <= latch_d;
`endif
      end
   end

   assign chip8_clk_out = chip8_clk_q;
   assign frame_out     = frame_q;
   assign dt_out        = dt_q;
   assign sound_on_out  = sound_q;
   assign running_out   = running_q;
   assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_chip8_scheduler.sv
// Scoreboard bench for chip8_scheduler: a cycle-indexed reference model pushes expected outputs,
// a negedge monitor pops and compares; directed phases follow the scheduler's documented scenarios.
`timescale 1ns/1ps
module tb_chip8_scheduler;
   localparam int T = 10;
   localparam int F = 40;

   logic       clk = 1'b0, rst = 1'b1;
   logic       proc_busy_in = 0, disp_wait_in = 0, pause_in = 0, resume_in = 0, step_in = 0;
   logic       dt_we_in = 0, st_we_in = 0;
   logic [7:0] timer_data_in = 0;
   logic       chip8_clk_out, frame_out, sound_on_out, running_out, overrun_out;
   logic [7:0] dt_out;

   always #5 clk = ~clk;

   chip8_scheduler #(.TICK_CYCLES(T), .FRAME_CYCLES(F), .START_RUN(1'b1)) dut (
      .clk_in(clk), .rst_in(rst), .proc_busy_in(proc_busy_in), .disp_wait_in(disp_wait_in),
      .pause_in(pause_in), .resume_in(resume_in), .step_in(step_in),
      .dt_we_in(dt_we_in), .st_we_in(st_we_in), .timer_data_in(timer_data_in),
      .chip8_clk_out(chip8_clk_out), .frame_out(frame_out), .dt_out(dt_out),
      .sound_on_out(sound_on_out), .running_out(running_out), .overrun_out(overrun_out));

   typedef struct packed {
      logic       strobe;
      logic       frame;
      logic [7:0] dt;
      logic       snd;
      logic       run;
      logic       ovr;
   } obs_t;

   obs_t exp_q[$];
   int   strobe_log[$];
   int   frame_log[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0;
   bit   mon_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: run mode, the cycle at which the current run began, a pending bit and the timers.
   typedef enum int {M_RUN, M_PAUSE, M_STEP} mode_t;
   mode_t m_mode;
   int    m_run_start;
   bit    m_pend, m_ovr, m_latch;
   int    m_dt, m_st;

   function automatic obs_t model_obs(input bit strobe, input bit frame);
      obs_t o;
      o.strobe = strobe;
      o.frame  = frame;
      o.dt     = 8'(m_dt);
      o.snd    = (m_st != 0);
      o.run    = (m_mode == M_RUN);
      o.ovr    = m_ovr;
      return o;
   endfunction

   task automatic model_reset();
      m_mode = M_RUN; m_run_start = 0; m_pend = 0; m_ovr = 0; m_latch = 0; m_dt = 0; m_st = 0;
   endtask

   // Given the inputs present during cycle c, derive what the outputs show in cycle c+1.
   task automatic model_step(input int c);
      mode_t start   = m_mode;
      bit    wrap    = (c % F) == F - 1;
      bit    due     = (start == M_RUN) && ((c - m_run_start) % T == T - 1);
      bit    strobe  = 0;
      bit    blocked = 0;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
      blocked = m_latch;
`endif
      if (due && m_pend) m_ovr = 1;
      if (pause_in) begin
         m_mode = M_PAUSE; m_pend = 0; m_latch = 0;
      end else begin
         bit want = m_pend || due;
         if (want && !proc_busy_in && !blocked) begin
            strobe = 1; m_pend = 0;
            if (start == M_STEP) m_mode = M_PAUSE;
         end else begin
            m_pend = want;
         end
`ifdef CHIP8_SCHED_DISP_WAIT_EN
         if (strobe && disp_wait_in) m_latch = 1;
         else if (wrap) m_latch = 0;
`endif
         if (resume_in && start != M_RUN) begin
            m_mode = M_RUN; m_run_start = c + 1; m_ovr = 0;
         end else if (step_in && start == M_PAUSE) begin
            m_mode = M_STEP; m_pend = 1;
         end
      end
      if (dt_we_in) m_dt = timer_data_in;
      else if (wrap && start == M_RUN && m_dt > 0) m_dt--;
      if (st_we_in) m_st = timer_data_in;
      else if (wrap && start == M_RUN && m_st > 0) m_st--;
      exp_q.push_back(model_obs(strobe, wrap));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         obs_t a, e;
         a = '{chip8_clk_out, frame_out, dt_out, sound_on_out, running_out, overrun_out};
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard empty at cycle %0d", cyc);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("cycle %0d {strobe,frame,dt,snd,run,ovr}", cyc), 32'(a), 32'(e));
         end
         if (chip8_clk_out) strobe_log.push_back(cyc);
         if (frame_out) frame_log.push_back(cyc);
      end
   end

   // Inputs set by the caller apply to the current cycle; pulses drop after the edge.
   task automatic tick();
      model_step(cyc);
      @(posedge clk);
      cyc++;
      #1;
      pause_in = 0; resume_in = 0; step_in = 0; dt_we_in = 0; st_we_in = 0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      mon_en = 0;
      rst = 1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 0;
      cyc = 0;
      model_reset();
      exp_q.push_back(model_obs(0, 0));
      strobe_log.delete();
      frame_log.delete();
      mon_en = 1;
   endtask

   initial begin
      int s0, f0, r0;

      // Free-running strobes and frames.
      do_reset();
      run(45);
      check("first strobe", strobe_log[0], 10);
      check("second strobe", strobe_log[1], 20);
      check("third strobe", strobe_log[2], 30);
      check("first frame", frame_log[0], 40);

      // Busy across one due, then across two dues.
      do_reset();
      while (cyc < 8) tick();
      proc_busy_in = 1;
      while (cyc < 15) tick();
      proc_busy_in = 0;
      while (cyc < 25) tick();
      check("delayed strobe", strobe_log[0], 16);
      proc_busy_in = 1;
      while (cyc < 42) tick();
      proc_busy_in = 0;
      run(3);
      check("overrun set", overrun_out, 1);
      check("single strobe after overrun", strobe_log[strobe_log.size() - 1], 43);
      pause_in = 1; tick();
      resume_in = 1; tick();
      run(1);
      check("overrun cleared by resume", overrun_out, 0);

      // Timers.
      do_reset();
      timer_data_in = 8'd3; dt_we_in = 1; tick();
      timer_data_in = 8'd1; st_we_in = 1; tick();
      while (cyc < 41) tick();
      check("dt after one frame", dt_out, 2);
      check("sound off after one frame", sound_on_out, 0);
      while (cyc < 165) tick();
      check("dt holds at zero", dt_out, 0);
      timer_data_in = 8'd9; dt_we_in = 1; tick();
      while (cyc < 199) tick();
      timer_data_in = 8'd5; dt_we_in = 1; tick();
      check("write beats decrement", dt_out, 5);

      // Pause, step, resume.
      pause_in = 1; tick();
      s0 = strobe_log.size();
      f0 = frame_log.size();
      run(100);
      check("no strobes while paused", strobe_log.size(), s0);
      check("frames while paused", 32'(frame_log.size() - f0 >= 2), 1);
      check("dt frozen while paused", dt_out, 5);
      r0 = cyc;
      step_in = 1; tick();
      run(2);
      check("step strobe count", strobe_log.size(), s0 + 1);
      check("step strobe latency", strobe_log[s0], r0 + 2);
      run(20);
      check("still one strobe after step", strobe_log.size(), s0 + 1);
      r0 = cyc;
      resume_in = 1; tick();
      run(12);
      // running_out rises at r0+1; the first strobe comes 10 cycles after that.
      check("first strobe after resume", strobe_log[s0 + 1], r0 + 11);

      // Asynchronous reset while a strobe is pending and dt = 7.
      do_reset();
      timer_data_in = 8'd7; dt_we_in = 1; tick();
      while (cyc < 5) tick();
      proc_busy_in = 1;
      while (cyc < 12) tick();
      mon_en = 0;
      #2 rst = 1;
      #1;
      check("async rst strobe", chip8_clk_out, 0);
      check("async rst frame", frame_out, 0);
      check("async rst dt", dt_out, 0);
      check("async rst sound", sound_on_out, 0);
      check("async rst running", running_out, 1);
      check("async rst overrun", overrun_out, 0);
      proc_busy_in = 0;
      do_reset();
      run(12);
      check("no stale strobe after reset", strobe_log[0], 10);

      // Draw-wait behaviour.
      do_reset();
      disp_wait_in = 1;
      run(85);
      disp_wait_in = 0;
`ifdef CHIP8_SCHED_DISP_WAIT_EN
      check("strobes with draw wait", strobe_log.size(), 3);
      check("strobe after frame release", strobe_log[1], 41);
`else
      check("strobes ignoring draw wait", strobe_log.size(), 8);
`endif

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         proc_busy_in  = ($urandom_range(0, 9) < 3);
         disp_wait_in  = ($urandom_range(0, 7) == 0);
         pause_in      = ($urandom_range(0, 149) == 0);
         resume_in     = ($urandom_range(0, 79) == 0);
         step_in       = ($urandom_range(0, 29) == 0);
         dt_we_in      = ($urandom_range(0, 59) == 0);
         st_we_in      = ($urandom_range(0, 59) == 0);
         timer_data_in = 8'($urandom_range(0, 255));
         tick();
      end
      proc_busy_in = 0; disp_wait_in = 0;
      @(negedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
